// File: rtl/sonar_pkg.sv
// sonar_pkg: state codes, frame constants and per-state control decode for sonar_uc.
package sonar_pkg;
   localparam int unsigned FRAME_LEN          = 8;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 2_500_000;

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      ESPERA         = 4'h2,
      MEDIDA         = 4'h3,
      AGUARDA_MEDIDA = 4'h4,
      TRANSMITE      = 4'h5,
      ESPERA_SERIAL  = 4'h6,
      PROXIMO_CHAR   = 4'h7,
      ATUALIZA       = 4'h8,
      TIMEOUT        = 4'hE
   } state_t;

   typedef struct packed {
      logic zera_timer;
      logic conta_timer;
      logic zera_posicao;
      logic conta_posicao;
      logic reset_servo;
      logic medir;
      logic zera_serial;
      logic conta_serial;
      logic partida_serial;
      logic medida_invalida;
   } ctrl_t;

   function automatic ctrl_t decode(state_t s);
      ctrl_t c;
      c.zera_timer      = s == PREPARACAO || s == ATUALIZA;
      c.conta_timer     = s == ESPERA;
      c.zera_posicao    = s == PREPARACAO;
      c.conta_posicao   = s == ATUALIZA;
      c.reset_servo     = s == PREPARACAO;
      c.medir           = s == MEDIDA;
      c.zera_serial     = s == PREPARACAO || s == ATUALIZA;
      c.conta_serial    = s == PROXIMO_CHAR;
      c.partida_serial  = s == TRANSMITE;
      c.medida_invalida = s == TIMEOUT;
      return c;
   endfunction
endpackage

// File: rtl/sonar_watchdog.sv
// sonar_watchdog: saturating up-counter with sync clear, enable and terminal-count flag.
module sonar_watchdog #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int unsigned W = LIMIT > 1 ? $clog2(LIMIT) : 1;
   logic [W-1:0] cnt_q;
   assign tc_o = cnt_q == W'(LIMIT - 1);
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) cnt_q <= '0;
      else if (en_i && !tc_o) cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/sonar_uc.sv
// sonar_uc: scan-step sequencer for the sweeping sonar (settle, measure, send frame, advance).
// Define SONAR_UC_TIMEOUT_EN to add the lost-measurement watchdog and TIMEOUT state.
module sonar_uc
   import sonar_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       fim_timer,
   input  logic       pronto_medida,
   input  logic       pronto_serial,
   input  logic       fim_transmissao,
   output logic       zera_timer,
   output logic       conta_timer,
   output logic       zera_posicao,
   output logic       conta_posicao,
   output logic       reset_servo,
   output logic       medir,
   output logic       zera_serial,
   output logic       conta_serial,
   output logic       partida_serial,
   output logic       medida_invalida,
   output logic [3:0] db_estado
);
   state_t state_q, state_d;
   ctrl_t  ctrl_q;
   logic   tc;

`ifdef SONAR_UC_TIMEOUT_EN
   sonar_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk_i(clock),
      .rst_i(reset),
      .clr_i(state_q != AGUARDA_MEDIDA),
      .en_i (state_q == AGUARDA_MEDIDA),
      .tc_o (tc)
   );
   assign medida_invalida = ctrl_q.medida_invalida;
`else
   logic unused_timeout;
   assign tc              = 1'b0;
   assign medida_invalida = 1'b0;
   assign unused_timeout  = ctrl_q.medida_invalida | (TIMEOUT_CYCLES != 0);
`endif

   // Serial states ignore ligar until the character in flight is done.
   always_comb begin
      state_d = INICIAL;
      case (state_q)
         INICIAL:        state_d = ligar ? PREPARACAO : INICIAL;
         PREPARACAO:     state_d = ESPERA;
         ESPERA:         state_d = !ligar ? INICIAL : fim_timer ? MEDIDA : ESPERA;
         MEDIDA:         state_d = ligar ? AGUARDA_MEDIDA : INICIAL;
         AGUARDA_MEDIDA: state_d = !ligar ? INICIAL : pronto_medida ? TRANSMITE :
                                   tc ? TIMEOUT : AGUARDA_MEDIDA;
         TRANSMITE:      state_d = ESPERA_SERIAL;
         ESPERA_SERIAL:  state_d = !pronto_serial ? ESPERA_SERIAL : !ligar ? INICIAL :
                                   fim_transmissao ? ATUALIZA : PROXIMO_CHAR;
         PROXIMO_CHAR:   state_d = TRANSMITE;
         ATUALIZA:       state_d = ligar ? ESPERA : INICIAL;
         TIMEOUT:        state_d = ligar ? ATUALIZA : INICIAL;
         default:        state_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      state_q <= reset ? INICIAL : state_d;
      ctrl_q  <= reset ? '0 : decode(state_d);
   end

   assign zera_timer     = ctrl_q.zera_timer;
   assign conta_timer    = ctrl_q.conta_timer;
   assign zera_posicao   = ctrl_q.zera_posicao;
   assign conta_posicao  = ctrl_q.conta_posicao;
   assign reset_servo    = ctrl_q.reset_servo;
   assign medir          = ctrl_q.medir;
   assign zera_serial    = ctrl_q.zera_serial;
   assign conta_serial   = ctrl_q.conta_serial;
   assign partida_serial = ctrl_q.partida_serial;
   assign db_estado      = state_q;
endmodule

// File: tb/tb_sonar_uc.sv
// tb_sonar_uc: directed table plus hand-written sequences for sonar_uc (TIMEOUT_CYCLES=16).
module tb_sonar_uc;
   logic clk = 1'b0, reset = 1'b1;
   logic ligar = 1'b0, fim_timer = 1'b0, pronto_medida = 1'b0, pronto_serial = 1'b0, fim_transmissao = 1'b0;
   logic zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo, medir;
   logic zera_serial, conta_serial, partida_serial, medida_invalida;
   logic [3:0] db_estado;
   logic [9:0] outs;
   int total = 0, bad = 0;
   int ps_cnt = 0, cs_cnt = 0, cp_cnt = 0, mi_cnt = 0, me_cnt = 0;

   typedef struct {
      int         n;
      logic       l, f, pm, ps, ft;
      logic [3:0] st;
   } vec_t;
   vec_t tbl [6];

   sonar_uc #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clk), .reset(reset), .ligar(ligar), .fim_timer(fim_timer),
      .pronto_medida(pronto_medida), .pronto_serial(pronto_serial),
      .fim_transmissao(fim_transmissao), .zera_timer(zera_timer),
      .conta_timer(conta_timer), .zera_posicao(zera_posicao),
      .conta_posicao(conta_posicao), .reset_servo(reset_servo), .medir(medir),
      .zera_serial(zera_serial), .conta_serial(conta_serial),
      .partida_serial(partida_serial), .medida_invalida(medida_invalida),
      .db_estado(db_estado)
   );

   always #5 clk = ~clk;

   assign outs = {zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo,
                  medir, zera_serial, conta_serial, partida_serial, medida_invalida};

   // Expected outputs per state: {zt,ct,zp,cp,rs,me,zs,cs,ps,mi}
   function automatic logic [9:0] exp_out(input logic [3:0] s);
      case (s)
         4'h1:    return 10'b1010101000;
         4'h2:    return 10'b0100000000;
         4'h3:    return 10'b0000010000;
         4'h5:    return 10'b0000000010;
         4'h7:    return 10'b0000000100;
         4'h8:    return 10'b1001001000;
         4'hE:    return 10'b0000000001;
         default: return 10'b0000000000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [3:0] st);
      total++;
      if (db_estado !== st || outs !== exp_out(st)) begin
         bad++;
         $display("FAIL %s: got state=%h outs=%b, want state=%h outs=%b", nm, db_estado, outs, st, exp_out(st));
      end
   endtask

   task automatic chk_eq(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic step(input logic l, input logic f, input logic pm, input logic ps, input logic ft);
      ligar = l; fim_timer = f; pronto_medida = pm; pronto_serial = ps; fim_transmissao = ft;
      @(posedge clk);
      #1;
      ps_cnt += int'(partida_serial);
      cs_cnt += int'(conta_serial);
      cp_cnt += int'(conta_posicao);
      mi_cnt += int'(medida_invalida);
      me_cnt += int'(medir);
   endtask

   initial begin
      int stray;
      tbl[0] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1};
      tbl[1] = '{9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
      tbl[2] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
      tbl[3] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4};
      tbl[4] = '{3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4};
      tbl[5] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5};

      repeat (2) @(posedge clk);
      #1;
      chk("reset", 4'h0);
      reset = 1'b0;
      step(0, 0, 0, 0, 0); chk("idle", 4'h0);

      ps_cnt = 0; cs_cnt = 0; cp_cnt = 0; me_cnt = 0;
      for (int i = 0; i < 6; i++)
         for (int k = 0; k < tbl[i].n; k++) begin
            step(tbl[i].l, tbl[i].f, tbl[i].pm, tbl[i].ps, tbl[i].ft);
            chk($sformatf("row%0d", i), tbl[i].st);
         end
      chk_eq("medir_pulses", me_cnt, 1);

      for (int c = 1; c <= 8; c++) begin
         step(1, 0, 0, 0, 0); chk("ser_wait", 4'h6);
         step(1, 0, 0, 1, c == 8); chk("ser_done", c == 8 ? 4'h8 : 4'h7);
         if (c < 8) begin
            step(1, 0, 0, 0, 0); chk("ser_tx", 4'h5);
         end
      end
      step(1, 0, 0, 0, 0); chk("back_espera", 4'h2);
      chk_eq("partida_pulses", ps_cnt, 8);
      chk_eq("conta_serial_pulses", cs_cnt, 7);
      chk_eq("conta_posicao_pulses", cp_cnt, 1);

      step(0, 0, 0, 0, 0); chk("drop_espera", 4'h0);

      step(1, 0, 0, 0, 0); chk("r2_prep", 4'h1);
      step(1, 0, 0, 0, 0); chk("r2_espera", 4'h2);
      step(1, 1, 0, 0, 0); chk("r2_medida", 4'h3);
      step(1, 0, 0, 0, 0); chk("r2_aguarda", 4'h4);
      step(1, 0, 1, 0, 0); chk("r2_tx", 4'h5);
      ps_cnt = 0;
      step(0, 0, 0, 0, 0); chk("drop_tx", 4'h6);
      step(0, 0, 0, 0, 0); chk("drop_wait", 4'h6);
      step(0, 0, 0, 1, 0); chk("drop_done", 4'h0);
      step(0, 0, 0, 0, 0); chk("drop_stay", 4'h0);
      chk_eq("drop_no_partida", ps_cnt, 0);

      step(1, 0, 0, 0, 0); chk("r3_prep", 4'h1);
      step(1, 0, 0, 0, 0); chk("r3_espera", 4'h2);
      step(1, 1, 0, 0, 0); chk("r3_medida", 4'h3);
      step(1, 0, 0, 0, 0); chk("r3_aguarda", 4'h4);
      reset = 1'b1;
      step(1, 0, 0, 0, 0); chk("reset_mid", 4'h0);
      reset = 1'b0;
      step(1, 0, 0, 0, 0); chk("r4_prep", 4'h1);
      step(1, 0, 0, 0, 0); chk("r4_espera", 4'h2);
      step(1, 1, 0, 0, 0); chk("r4_medida", 4'h3);
      step(1, 0, 0, 0, 0); chk("r4_aguarda", 4'h4);
      mi_cnt = 0; ps_cnt = 0;
`ifdef SONAR_UC_TIMEOUT_EN
      for (int k = 0; k < 15; k++) begin
         step(1, 0, 0, 0, 0); chk("wd_count", 4'h4);
      end
      step(1, 0, 0, 0, 0); chk("timeout", 4'hE);
      step(1, 0, 0, 0, 0); chk("timeout_atualiza", 4'h8);
      step(1, 0, 0, 0, 0); chk("timeout_espera", 4'h2);
      chk_eq("timeout_pulses", mi_cnt, 1);
      chk_eq("timeout_no_partida", ps_cnt, 0);
      step(1, 1, 0, 0, 0); chk("r5_medida", 4'h3);
      step(1, 0, 0, 0, 0); chk("r5_aguarda", 4'h4);
      mi_cnt = 0;
      for (int k = 0; k < 15; k++) step(1, 0, 0, 0, 0);
      chk("r5_at_tc", 4'h4);
      step(1, 0, 1, 0, 0); chk("pm_wins", 4'h5);
      step(1, 0, 0, 0, 0); chk("pm_wins_wait", 4'h6);
      chk_eq("pm_wins_no_invalid", mi_cnt, 0);
`else
      stray = 0;
      for (int k = 0; k < 10000; k++) begin
         step(1, 0, 0, 0, 0);
         if (db_estado !== 4'h4) stray++;
      end
      chk_eq("no_timeout_stray", stray + mi_cnt, 0);
      step(1, 0, 1, 0, 0); chk("late_pm", 4'h5);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
